// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, and iterative op kinds.
// The optional divider is enabled with `define ALU_DIV_EN.
package alu_pkg;

  localparam int ALUOP_W = 4;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_MUL  = 4'b1000;
  localparam logic [3:0] ALU_DIVU = 4'b1001;
  localparam logic [3:0] ALU_REMU = 4'b1010;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef enum logic [1:0] {IT_MUL, IT_DIVU, IT_REMU} iter_op_t;

endpackage

// File: rtl/alu_iter_core.sv
// Iterative datapath: shift-add multiplier and, with `define ALU_DIV_EN, a restoring
// divider sharing the operand (x) register, the accumulator and the iteration counter.
// One iteration per cycle for WIDTH cycles after start; done and result are combinational
// on the last iteration so the caller can register the final value on that edge.
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  iter_op_t         op_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             active;
  logic [CNT_W-1:0] cnt;
  iter_op_t         op_q;
  logic [WIDTH-1:0] x_q, y_q, acc_q;
  logic [WIDTH-1:0] x_n, y_n, acc_n;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]   shifted;
`endif

  // Next-iteration values; for division x holds dividend bits shifting out and quotient bits shifting in
  always_comb begin
    x_n   = x_q;
    y_n   = y_q;
    acc_n = acc_q;
`ifdef ALU_DIV_EN
    shifted = {acc_q, x_q[WIDTH-1]};
    if (op_q == IT_MUL) begin
      if (y_q[0]) acc_n = acc_q + x_q;
      x_n = x_q << 1;
      y_n = y_q >> 1;
    end else begin
      x_n = {x_q[WIDTH-2:0], 1'b0};
      if (shifted >= {1'b0, y_q}) begin
        acc_n  = shifted[WIDTH-1:0] - y_q;
        x_n[0] = 1'b1;
      end else begin
        acc_n = shifted[WIDTH-1:0];
      end
    end
`else
    if (y_q[0]) acc_n = acc_q + x_q;
    x_n = x_q << 1;
    y_n = y_q >> 1;
`endif
  end

  // Final result selection and completion flag
  always_comb begin
    done = active && (cnt == '0);
`ifdef ALU_DIV_EN
    case (op_q)
      IT_DIVU: result = x_n;
      default: result = acc_n;
    endcase
`else
    result = (op_q == IT_MUL) ? acc_n : '0;
`endif
  end

  // Operand capture on start, then one iteration per cycle counting WIDTH-1 down to 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active <= 1'b0;
      cnt    <= '0;
      op_q   <= IT_MUL;
      x_q    <= '0;
      y_q    <= '0;
      acc_q  <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= CNT_W'(WIDTH - 1);
      op_q   <= op_in;
      x_q    <= a;
      y_q    <= b;
      acc_q  <= '0;
    end else if (active) begin
      x_q   <= x_n;
      y_q   <= y_n;
      acc_q <= acc_n;
      if (cnt == '0) active <= 1'b0;
      else           cnt    <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq_muldiv.sv
// Multi-cycle ALU behind valid/ready handshakes. Logic/ADD/SUB complete in one cycle,
// MUL (and DIVU/REMU with `define ALU_DIV_EN) iterate for WIDTH cycles in alu_iter_core.
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int ALUOP_W = alu_pkg::ALUOP_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [ALUOP_W-1:0] aluop,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   res,
  output logic               zero,
  output logic               busy
);

  state_t           state;
  logic [WIDTH-1:0] single_res;
  logic             is_iter;
  iter_op_t         iter_op;
  logic             accept;
  logic             core_done;
  logic [WIDTH-1:0] core_result;

  assign accept = in_valid && in_ready;

  // Opcode decode and single-cycle results; unknown opcodes fall through to zero
  always_comb begin
    single_res = '0;
    is_iter    = 1'b0;
    iter_op    = IT_MUL;
    case (aluop)
      ALUOP_W'(ALU_AND): single_res = a & b;
      ALUOP_W'(ALU_OR):  single_res = a | b;
      ALUOP_W'(ALU_ADD): single_res = a + b;
      ALUOP_W'(ALU_SUB): single_res = a - b;
      ALUOP_W'(ALU_NOR): single_res = ~(a | b);
      ALUOP_W'(ALU_MUL): is_iter    = 1'b1;
`ifdef ALU_DIV_EN
      ALUOP_W'(ALU_DIVU): begin
        is_iter = 1'b1;
        iter_op = IT_DIVU;
      end
      ALUOP_W'(ALU_REMU): begin
        is_iter = 1'b1;
        iter_op = IT_REMU;
      end
`endif
      default: single_res = '0;
    endcase
  end

  alu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (accept && is_iter),
    .op_in   (iter_op),
    .a       (a),
    .b       (b),
    .done    (core_done),
    .result  (core_result)
  );

  // Control FSM with registered handshake, status and result outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      res       <= '0;
      zero      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (is_iter) begin
              state <= BUSY;
              busy  <= 1'b1;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              res       <= single_res;
              zero      <= (single_res == '0);
            end
          end
        end
        BUSY: begin
          if (core_done) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            res       <= core_result;
            zero      <= (core_result == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Self-checking bench for alu_seq_muldiv (WIDTH=64): directed table, handshake corner
// sequences, and randomized ops against an arithmetic reference model.
module tb_alu_seq_muldiv;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [3:0]   aluop;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic         zero;
  logic         busy;

  int nvec  = 0;
  int nfail = 0;

  alu_seq_muldiv #(.WIDTH(W), .ALUOP_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .aluop     (aluop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] exp_res;
    int           exp_lat;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference arithmetic straight from the opcode table
  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    case (op)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b1100: return ~(x | y);
      4'b1000: return x * y;
`ifdef ALU_DIV_EN
      4'b1001: return (y == 0) ? '1 : x / y;
      4'b1010: return (y == 0) ? x : x % y;
`endif
      default: return '0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op);
    if (op == 4'b1000) return W + 1;
`ifdef ALU_DIV_EN
    if (op == 4'b1001 || op == 4'b1010) return W + 1;
`endif
    return 1;
  endfunction

  // Issue one op with out_ready=1, measure latency (accept edge counts as cycle 1), check result
  task automatic run_op(input string nm, input logic [3:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] exp_res, input int exp_lat);
    int  lat;
    bit  stall_ok;
    @(negedge clk);
    check({nm, ".in_ready"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; aluop = op; a = x; b = y;
    @(negedge clk);
    in_valid = 1'b0; a = ~x; b = ~y; aluop = 4'b0010;
    lat = 1;
    stall_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (!busy || in_ready) stall_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({nm, ".out_valid"}, {63'd0, out_valid}, 64'd1);
    check({nm, ".latency"}, 64'(lat), 64'(exp_lat));
    check({nm, ".stall"}, {63'd0, stall_ok}, 64'd1);
    check({nm, ".res"}, res, exp_res);
    check({nm, ".zero"}, {63'd0, zero}, {63'd0, exp_res == 0});
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, ".in_ready"},  {63'd0, in_ready},  64'd1);
    check({nm, ".out_valid"}, {63'd0, out_valid}, 64'd0);
    check({nm, ".busy"},      {63'd0, busy},      64'd0);
    check({nm, ".res"},       res,                64'd0);
    check({nm, ".zero"},      {63'd0, zero},      64'd1);
  endtask

  initial begin
    logic [3:0] ops [9];
    int         ov_cnt;

    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1000, 4'b1001, 4'b1010, 4'b0111};

    tbl.push_back('{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1});
    tbl.push_back('{4'b1000, 64'h1_0000_0003, 64'd5, 64'h5_0000_000F, W + 1});
    tbl.push_back('{4'b0110, 64'd7, 64'd9, 64'hFFFF_FFFF_FFFF_FFFE, 1});
    tbl.push_back('{4'b1100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1});
    tbl.push_back('{4'b0000, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF, 64'h00F0_1234_0000_9ABC, 1});
    tbl.push_back('{4'b0001, 64'hF000_0000_0000_0001, 64'h0000_0000_0000_0100, 64'hF000_0000_0000_0101, 1});
    tbl.push_back('{4'b0111, 64'd123, 64'd456, 64'd0, 1});
    tbl.push_back('{4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, W + 1});
`ifdef ALU_DIV_EN
    tbl.push_back('{4'b1001, 64'd100, 64'd7, 64'd14, W + 1});
    tbl.push_back('{4'b1010, 64'd100, 64'd7, 64'd2, W + 1});
    tbl.push_back('{4'b1001, 64'h1234_5678, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, W + 1});
    tbl.push_back('{4'b1010, 64'd5, 64'd0, 64'd5, W + 1});
`else
    tbl.push_back('{4'b1001, 64'd100, 64'd7, 64'd0, 1});
    tbl.push_back('{4'b1010, 64'd100, 64'd7, 64'd0, 1});
`endif

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; aluop = '0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    reset_n = 1'b1;

    foreach (tbl[i])
      run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].exp_res, tbl[i].exp_lat);

    // Result held while consumer stalls; a second request is not taken
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; aluop = 4'b0110; a = 64'd7; b = 64'd9;
    @(negedge clk);
    aluop = 4'b0010; a = 64'd1; b = 64'd1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("hold%0d.out_valid", i), {63'd0, out_valid}, 64'd1);
      check($sformatf("hold%0d.res", i), res, 64'hFFFF_FFFF_FFFF_FFFE);
      check($sformatf("hold%0d.in_ready", i), {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("hold.release_valid", {63'd0, out_valid}, 64'd0);
    check("hold.release_ready", {63'd0, in_ready}, 64'd1);
    check("hold.release_res", res, 64'hFFFF_FFFF_FFFF_FFFE);

    // Reset during a multiply discards it
    in_valid = 1'b1; aluop = 4'b1000; a = 64'd3; b = 64'd4;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_state("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    ov_cnt = 0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    check("midreset.no_out_valid", 64'(ov_cnt), 64'd0);
    run_op("post_reset_nor", 4'b1100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);

    // Randomized back-to-back ops against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [3:0]   op;
      logic [W-1:0] x, y;
      op = ops[$urandom_range(0, 8)];
      x  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       y = '0;
        1:       y = 64'($urandom_range(1, 255));
        2:       y = {32'd0, $urandom};
        default: y = {$urandom, $urandom};
      endcase
      run_op($sformatf("rnd%0d", i), op, x, y, model(op, x, y), model_lat(op));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
